// File: rtl/pe_1st_feeder.sv
// Job sequencer for one PE_1st: flushes the accumulator, streams K*K weight/pixel pairs
// from the synchronous buffers, aligns the PE enables and returns the captured sum.
module pe_1st_feeder #(
    parameter int unsigned K     = 3,
    parameter int unsigned IMG_W = 28,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] w_base_i,
    input  logic [AW-1:0] p_base_i,
    output logic          busy_o,
    output logic          w_rd_o,
    output logic [AW-1:0] w_addr_o,
    input  logic [7:0]    w_data_i,
    output logic          p_rd_o,
    output logic [AW-1:0] p_addr_o,
    input  logic [7:0]    p_data_i,
    output logic [7:0]    pe_weight_o,
    output logic [7:0]    pe_pixel_o,
    output logic          pe_en_o,
    output logic          pe_flush_o,
    input  logic [31:0]   pe_result_i,
    output logic          res_valid_o,
    output logic [31:0]   res_data_o,
    input  logic          res_ready_i
);

    localparam int unsigned TAPS = K * K;
    localparam int unsigned CW   = $clog2(TAPS + 3);
    localparam int unsigned KW   = $clog2(K + 1);

    localparam logic [AW-1:0] ImgStep   = AW'(IMG_W);
    localparam logic [CW-1:0] LastTap   = CW'(TAPS - 1);
    localparam logic [CW-1:0] LastDrain = CW'(2);
    localparam logic [KW-1:0] LastCol   = KW'(K - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StFetch,
        StDrain,
        StResult
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [KW-1:0] col_q;
    logic [AW-1:0] row_base_q;
    logic          en1_q;

    assign pe_weight_o = w_data_i;
    assign pe_pixel_o  = p_data_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            en1_q       <= 1'b0;
            busy_o      <= 1'b0;
            w_rd_o      <= 1'b0;
            p_rd_o      <= 1'b0;
            w_addr_o    <= '0;
            p_addr_o    <= '0;
            pe_en_o     <= 1'b0;
            pe_flush_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
        end else begin
            // Stage 1 covers the buffer read latency, stage 2 the PE multiplier register.
            en1_q   <= w_rd_o;
            pe_en_o <= en1_q;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StFlush;
                        busy_o     <= 1'b1;
                        pe_flush_o <= 1'b1;
                        w_addr_o   <= w_base_i;
                        p_addr_o   <= p_base_i;
                        row_base_q <= p_base_i;
                    end
                end
                StFlush: begin
                    state_q    <= StFetch;
                    pe_flush_o <= 1'b0;
                    w_rd_o     <= 1'b1;
                    p_rd_o     <= 1'b1;
                    cnt_q      <= '0;
                    col_q      <= '0;
                end
                StFetch: begin
                    if (cnt_q == LastTap) begin
                        state_q <= StDrain;
                        w_rd_o  <= 1'b0;
                        p_rd_o  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q    <= cnt_q + CW'(1);
                        w_addr_o <= w_addr_o + AW'(1);
                        // Row step is accumulated so the pixel address needs no multiplier.
                        if (col_q == LastCol) begin
                            col_q      <= '0;
                            row_base_q <= row_base_q + ImgStep;
                            p_addr_o   <= row_base_q + ImgStep;
                        end else begin
                            col_q    <= col_q + KW'(1);
                            p_addr_o <= p_addr_o + AW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (cnt_q == LastDrain) begin
                        state_q     <= StResult;
                        res_data_o  <= pe_result_i;
                        res_valid_o <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StResult: begin
                    if (res_ready_i) begin
                        state_q     <= StIdle;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_1st_feeder.sv
// Directed bench for pe_1st_feeder with behavioural buffers, a PE model and a result scoreboard.
module tb_pe_1st_feeder;

    localparam int K     = 3;
    localparam int TAPS  = K * K;
    localparam int IMG_W = 28;
    localparam int AW    = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic [AW-1:0]        w_base_i = '0;
    logic [AW-1:0]        p_base_i = '0;
    logic                 busy_o;
    logic                 w_rd_o;
    logic [AW-1:0]        w_addr_o;
    logic signed [7:0]    w_data_i = '0;
    logic                 p_rd_o;
    logic [AW-1:0]        p_addr_o;
    logic signed [7:0]    p_data_i = '0;
    logic signed [7:0]    pe_weight_o;
    logic signed [7:0]    pe_pixel_o;
    logic                 pe_en_o;
    logic                 pe_flush_o;
    logic signed [31:0]   pe_result_i;
    logic                 res_valid_o;
    logic [31:0]          res_data_o;
    logic                 res_ready_i = 1'b0;

    pe_1st_feeder #(.K(K), .IMG_W(IMG_W), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .w_base_i    (w_base_i),
        .p_base_i    (p_base_i),
        .busy_o      (busy_o),
        .w_rd_o      (w_rd_o),
        .w_addr_o    (w_addr_o),
        .w_data_i    (w_data_i),
        .p_rd_o      (p_rd_o),
        .p_addr_o    (p_addr_o),
        .p_data_i    (p_data_i),
        .pe_weight_o (pe_weight_o),
        .pe_pixel_o  (pe_pixel_o),
        .pe_en_o     (pe_en_o),
        .pe_flush_o  (pe_flush_o),
        .pe_result_i (pe_result_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_ready_i (res_ready_i)
    );

    always #5 clk = ~clk;

    logic signed [7:0] wmem [1024];
    logic signed [7:0] pmem [1024];

    always @(posedge clk) begin
        w_data_i <= w_rd_o ? wmem[w_addr_o] : 8'sd0;
        p_data_i <= p_rd_o ? pmem[p_addr_o] : 8'sd0;
    end

    // PE_1st model: registered multiplier feeding a flushable accumulator.
    logic signed [15:0] mult_q = '0;
    logic signed [31:0] acc_q  = '0;
    always @(posedge clk) begin
        mult_q <= pe_weight_o * pe_pixel_o;
        if (pe_flush_o)   acc_q <= '0;
        else if (pe_en_o) acc_q <= acc_q + 32'(mult_q);
    end
    assign pe_result_i = acc_q;

    int            en_cnt = 0;
    logic          overlap_seen = 1'b0;
    logic [AW-1:0] waddr_log [$];
    logic [AW-1:0] paddr_log [$];
    always @(posedge clk) begin
        if (pe_en_o) en_cnt <= en_cnt + 1;
        if (pe_en_o && pe_flush_o) overlap_seen <= 1'b1;
        if (w_rd_o) begin
            waddr_log.push_back(w_addr_o);
            paddr_log.push_back(p_addr_o);
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] pb,
                           input logic [31:0] want, input int hold, input logic poke);
        int lat;
        int en0;
        logic [AW-1:0] ea;
        sb.push_back(want);
        waddr_log.delete();
        paddr_log.delete();
        en0 = en_cnt;
        @(negedge clk);
        start_i = 1'b1; w_base_i = wb; p_base_i = pb;
        @(negedge clk);
        start_i = 1'b0; w_base_i = '0; p_base_i = '0;
        lat = 1;
        check("flush_phase", {busy_o, pe_flush_o, pe_en_o, w_rd_o}, 32'b1100);
        while (!res_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5) begin
                start_i = 1'b1; w_base_i = 10'd500; p_base_i = 10'd600;
            end
            if (poke && lat == 6) start_i = 1'b0;
        end
        check("valid_latency", lat, 32'd14);
        for (int h = 0; h < hold; h++) begin
            if (poke) start_i = (h == 1);
            check("hold_valid_busy", {res_valid_o, busy_o}, 32'b11);
            check("hold_data", res_data_o, want);
            @(negedge clk);
        end
        start_i = 1'b0;
        res_ready_i = 1'b1;
        if (sb.size() > 0) check("res_data", res_data_o, sb.pop_front());
        else check("sb_empty", 32'd0, 32'd1);
        @(negedge clk);
        res_ready_i = 1'b0;
        check("idle_after_accept", {res_valid_o, busy_o}, 32'b00);
        check("en_cycles", en_cnt - en0, TAPS);
        check("rd_count", waddr_log.size(), TAPS);
        for (int i = 0; i < TAPS && i < waddr_log.size(); i++) begin
            ea = wb + AW'(i);
            check("w_addr", waddr_log[i], ea);
            ea = pb + AW'((i / K) * IMG_W + (i % K));
            check("p_addr", paddr_log[i], ea);
        end
    endtask

    int   exp_p [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    logic seen;

    initial begin
        for (int a = 0; a < 1024; a++) begin
            wmem[a] = 8'sd0;
            pmem[a] = 8'sd0;
        end
        for (int i = 0; i < TAPS; i++) begin
            wmem[i]       = 8'sd1;
            wmem[100 + i] = 8'sd2;
            wmem[200 + i] = -8'sd128;
            wmem[220 + i] = 8'sd127;
            pmem[exp_p[i]]       = 8'(i + 1);
            pmem[300 + exp_p[i]] = -8'sd128;
        end
        for (int i = 1021; i < 1024; i++) wmem[i] = 8'sd3;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy_o, w_rd_o, p_rd_o, pe_en_o, pe_flush_o, res_valid_o}, 32'd0);
        check("rst_addr", {w_addr_o, p_addr_o}, 32'd0);
        check("rst_data", res_data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(10'd0, 10'd0, 32'd45, 0, 1'b0);
        for (int i = 0; i < TAPS && i < paddr_log.size(); i++)
            check("p_addr_list", paddr_log[i], exp_p[i]);
        run_job(10'd100, 10'd0, 32'd90, 0, 1'b0);
        run_job(10'd0, 10'd0, 32'd45, 5, 1'b1);
        run_job(10'd200, 10'd300, 32'd147456, 0, 1'b0);
        run_job(10'd220, 10'd300, -32'sd146304, 0, 1'b0);

        // Abandon a job during FETCH tap 4.
        @(negedge clk);
        start_i = 1'b1; w_base_i = '0; p_base_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", {busy_o, w_rd_o, p_rd_o, pe_en_o, pe_flush_o, res_valid_o}, 32'd0);
        check("midrst_addr", {w_addr_o, p_addr_o}, 32'd0);
        check("midrst_data", res_data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_en", pe_en_o, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1;
        end
        check("midrst_no_result", seen, 1'b0);

        run_job(10'd0, 10'd0, 32'd45, 0, 1'b0);
        run_job(10'd1021, 10'd0, 32'd57, 0, 1'b0);
        if (waddr_log.size() > 3) begin
            check("wrap_1023", waddr_log[2], 10'd1023);
            check("wrap_0", waddr_log[3], 10'd0);
        end else begin
            check("wrap_log", waddr_log.size(), 32'd9);
        end
        check("flush_en_overlap", overlap_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
